// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundle of every signal between the two-requester memory arbiter and its
//   surroundings: requester A (CPU), requester B (loader/DMA/debug), and the
//   single-port memory.
//
//   Signals
//     a_req/a_we/a_addr/a_wdata   request from A (held stable until a_ack)
//     a_ack/a_rdata               completion strobe and read data to A
//     b_req/b_we/b_addr/b_wdata   request from B (held stable until b_ack)
//     b_ack/b_rdata               completion strobe and read data to B
//     mem_addr/mem_we/mem_wdata   memory command driven by the arbiter
//     mem_rdata                   memory read data (combinational from mem_addr)
//     owner                       00 none, 01 A, 10 B
//
//   Modports
//     slave   the arbiter's view
//     master  the environment's view (requesters plus memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // requester A
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ack;
    logic [DW-1:0] a_rdata;

    // requester B
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;

    // memory side
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // current owner of the memory access
    logic [1:0]    owner;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output owner
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester arbiter for the single-port unified instruction/data
//   memory. Port A (CPU) has fixed priority; a loss counter forces port B to
//   win after it has lost MAX_WAIT arbitrations in a row.
//
//   Every access takes three cycles: IDLE (arbitrate) -> SERVE (memory
//   command driven combinationally from the owner's inputs, read data
//   captured at the closing edge) -> ACK (one-cycle ack strobe to the owner).
//
//   Ports
//     clk     rising-edge clock
//     reset   asynchronous, active-low reset (0 = reset)
//     bus     mem_arbiter_if.slave: requester A/B handshakes, memory command
//             and read data, owner indication
//
//   Parameters
//     AW        address width
//     DW        data width
//     MAX_WAIT  arbitrations B may lose in a row before it is forced to win
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int LW = $clog2(MAX_WAIT + 1);
    localparam logic [LW-1:0] LOSS_LIMIT = LW'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_ACK
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_A    = 2'b01,
        OWN_B    = 2'b10
    } owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [LW-1:0] loss_q,  loss_d;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;

    // Owner's request, selected for the memory command in SERVE.
    logic          sel_b;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;

    // Combinational outputs.
    logic          a_ack;
    logic          b_ack;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    assign sel_b     = (owner_q == OWN_B);
    assign cur_we    = sel_b ? bus.b_we    : bus.a_we;
    assign cur_addr  = sel_b ? bus.b_addr  : bus.a_addr;
    assign cur_wdata = sel_b ? bus.b_wdata : bus.a_wdata;

    // -----------------------------------------------------------------------
    // State, owner, loss counter and read-data registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            loss_q    <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            loss_q  <= loss_d;
            // Read data is captured at the edge closing SERVE; a write
            // leaves the owner's read data untouched.
            if (state_q == ST_SERVE && !cur_we) begin
                if (sel_b) begin
                    b_rdata_q <= bus.mem_rdata;
                end else begin
                    a_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state, arbitration and outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        loss_d    = loss_q;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            ST_IDLE: begin
                owner_d = OWN_NONE;
                if (bus.a_req && bus.b_req) begin
                    // Contention: A wins until B has lost MAX_WAIT times.
                    state_d = ST_SERVE;
                    if (loss_q < LOSS_LIMIT) begin
                        owner_d = OWN_A;
                        loss_d  = loss_q + LW'(1);
                    end else begin
                        owner_d = OWN_B;
                        loss_d  = '0;
                    end
                end else if (bus.a_req) begin
                    // B not requesting: counter left alone.
                    state_d = ST_SERVE;
                    owner_d = OWN_A;
                end else if (bus.b_req) begin
                    state_d = ST_SERVE;
                    owner_d = OWN_B;
                    loss_d  = '0;
                end
            end

            ST_SERVE: begin
                mem_we    = cur_we;
                mem_addr  = cur_addr;
                mem_wdata = cur_wdata;
                state_d   = ST_ACK;
            end

            ST_ACK: begin
                a_ack   = (owner_q == OWN_A);
                b_ack   = (owner_q == OWN_B);
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end

            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    assign bus.a_ack     = a_ack;
    assign bus.b_ack     = b_ack;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: directed scenarios followed by
//   randomized request traffic, checked against a transaction-level model
//   (arbitration rule, loss count, reference memory, held read data).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- memory environment ----------------
    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 16'h0010) return 16'hBEEF;
        return DW'(i * 37) ^ 16'h5A5A;
    endfunction

    logic [DW-1:0] mem [65536];
    logic          mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [65536];
    int            m_cnt;
    logic [DW-1:0] m_a_rdata;
    logic [DW-1:0] m_b_rdata;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        m_a_rdata = '0;
        m_b_rdata = '0;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    endtask

    // Random new request for a requester that is free to change its inputs.
    task automatic rand_req(input int which, input int pct);
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        req  = ($urandom_range(0, 99) < pct);
        we   = $urandom_range(0, 1) == 1;
        addr = AW'($urandom_range(0, 31));
        wd   = DW'($urandom);
        if (which == 1) set_a(req, we, addr, wd);
        else            set_b(req, we, addr, wd);
    endtask

    // One arbitration round, entered and left on the falling edge of an
    // IDLE cycle. Inputs present at entry are what the next edge samples.
    task automatic do_round(output logic [1:0] who);
        logic          a;
        logic          b;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;

        a = bus.a_req;
        b = bus.b_req;
        check_val("idle_owner", bus.owner, 0);
        check_val("idle_we", bus.mem_we, 0);
        check_val("idle_addr", bus.mem_addr, 0);

        if (!a && !b) begin
            who = 2'd0;
            @(negedge clk);
            return;
        end

        if (a && b) begin
            if (m_cnt < MAX_WAIT) begin who = 2'd1; m_cnt++; end
            else                  begin who = 2'd2; m_cnt = 0; end
        end else if (a) begin
            who = 2'd1;
        end else begin
            who = 2'd2;
            m_cnt = 0;
        end

        if (who == 2'd1) begin we = bus.a_we; addr = bus.a_addr; wd = bus.a_wdata; end
        else             begin we = bus.b_we; addr = bus.b_addr; wd = bus.b_wdata; end

        @(negedge clk); // SERVE
        check_val("serve_owner", bus.owner, 32'(who));
        check_val("serve_addr", bus.mem_addr, 32'(addr));
        check_val("serve_we", bus.mem_we, 32'(we));
        check_val("serve_wdata", bus.mem_wdata, 32'(wd));
        check_val("serve_ack", {bus.a_ack, bus.b_ack}, 0);

        @(negedge clk); // ACK
        if (we) ref_mem[addr] = wd;
        else if (who == 2'd1) m_a_rdata = ref_mem[addr];
        else m_b_rdata = ref_mem[addr];
        check_val("ack_a", bus.a_ack, 32'(who == 2'd1));
        check_val("ack_b", bus.b_ack, 32'(who == 2'd2));
        check_val("ack_we", bus.mem_we, 0);
        check_val("ack_addr", bus.mem_addr, 0);
        check_val("ack_wdata", bus.mem_wdata, 0);
        check_val("a_rdata", bus.a_rdata, 32'(m_a_rdata));
        check_val("b_rdata", bus.b_rdata, 32'(m_b_rdata));

        @(negedge clk); // back in IDLE
        check_val("ack_drop", {bus.a_ack, bus.b_ack}, 0);
        check_val("a_rdata_hold", bus.a_rdata, 32'(m_a_rdata));
        check_val("b_rdata_hold", bus.b_rdata, 32'(m_b_rdata));
    endtask

    task automatic check_all_zero(input string pfx);
        check_val({pfx, "_owner"}, bus.owner, 0);
        check_val({pfx, "_acks"}, {bus.a_ack, bus.b_ack}, 0);
        check_val({pfx, "_a_rdata"}, bus.a_rdata, 0);
        check_val({pfx, "_b_rdata"}, bus.b_rdata, 0);
        check_val({pfx, "_mem_we"}, bus.mem_we, 0);
        check_val({pfx, "_mem_addr"}, bus.mem_addr, 0);
        check_val({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    initial begin
        logic [1:0] w;
        logic [DW-1:0] a_snap;

        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        mem_init = 1'b1;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        model_reset();

        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        check_all_zero("rst");

        // Release reset and request in the same cycle: first arbitration is
        // at the very next edge. A reads 0x0010.
        reset = 1'b1;
        set_a(1'b1, 1'b0, 16'h0010, '0);
        do_round(w);
        check_val("t2_winner", w, 1);
        check_val("t2_rdata", bus.a_rdata, 16'hBEEF);
        set_a(1'b0, 1'b0, '0, '0);

        // B writes 0x1234 to 0x0020, A reads it back.
        set_b(1'b1, 1'b1, 16'h0020, 16'h1234);
        do_round(w);
        check_val("t3_winner", w, 2);
        set_b(1'b0, 1'b0, '0, '0);
        set_a(1'b1, 1'b0, 16'h0020, '0);
        do_round(w);
        check_val("t3_rdata", bus.a_rdata, 16'h1234);
        check_val("t3_b_rdata", bus.b_rdata, 16'h0000);
        set_a(1'b0, 1'b0, '0, '0);

        // B alone is served immediately.
        set_b(1'b1, 1'b0, 16'h0010, '0);
        do_round(w);
        check_val("t5_winner", w, 2);
        check_val("t5_b_rdata", bus.b_rdata, 16'hBEEF);

        // Both held continuously: A,A,A,A,B repeating.
        rand_req(1, 100);
        rand_req(2, 100);
        for (int i = 0; i < 15; i++) begin
            do_round(w);
            check_val("t4_order", w, (i % 5 == 4) ? 2 : 1);
            rand_req(int'(w), 100);
        end
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        do_round(w);
        check_val("t4_idle", w, 0);

        // Randomized traffic.
        rand_req(1, 60);
        rand_req(2, 60);
        for (int i = 0; i < 400; i++) begin
            do_round(w);
            if (w != 2'd2) rand_req(1, 60);
            if (w != 2'd1) rand_req(2, 60);
        end
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        do_round(w);

        // Reset asserted in the middle of a SERVE write.
        set_b(1'b1, 1'b1, 16'h0030, 16'hDEAD);
        @(negedge clk);
        check_val("t6_serve_we", bus.mem_we, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("t6_async");
        @(negedge clk);
        set_b(1'b0, 1'b0, '0, '0);
        check_all_zero("t6_held");
        check_val("t6_mem_kept", mem[16'h0030], 32'(ref_mem[16'h0030]));
        model_reset();
        reset = 1'b1;
        do_round(w);
        check_val("t1_idle_after", w, 0);
        set_a(1'b1, 1'b0, 16'h0030, '0);
        a_snap = ref_mem[16'h0030];
        do_round(w);
        check_val("t6_readback", bus.a_rdata, 32'(a_snap));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
